bcd_entry_ctrl: RTL and testbench

Sequential controller that collects a multi-digit decimal number one 4-bit BCD digit at a time over a valid/ready handshake. Validates each digit (legal range 0..9) and assembles accepted digits into a packed BCD register. Reports completion or a coded input error. Sits between a digit source (keypad decoder or stimulus driver) and downstream BCD consumers such as display drivers or BCD-to-binary converters.

---
 rtl/bcd_entry_pkg.sv | 17 +
 rtl/bcd_digit_check.sv | 11 +
 rtl/bcd_entry_ctrl.sv | 139 +++++++++++++
 tb/tb_bcd_entry_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the BCD digit-entry controller.
package bcd_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } entry_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DIGIT   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational BCD digit legality check: a nibble is legal when it is 0..9.
module bcd_digit_check
    import bcd_entry_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic       isLegal_o
);

    assign isLegal_o = (digit_i <= BCD_MAX);

endmodule

// File: rtl/bcd_entry_ctrl.sv
// Multi-digit BCD entry controller: accepts digits over valid/ready, validates
// them, shifts them into a packed BCD register and flags completion, illegal
// digits or idle timeouts. Optional binary output enabled by the macro
// BCD_ENTRY_BIN_OUT_EN.
module bcd_entry_ctrl
    import bcd_entry_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 255
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              clear,
    input  logic [3:0]                        digit_in,
    input  logic                              digit_valid,
    output logic                              digit_ready,
    output logic [4*NUM_DIGITS-1:0]           bcd_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              done,
    output logic                              input_err,
    output logic [1:0]                        err_code
`ifdef BCD_ENTRY_BIN_OUT_EN
    ,
    output logic [$clog2(10**NUM_DIGITS)-1:0] bin_out
`endif
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    entry_state_t   state_q;
    logic [BW-1:0]  bcd_q;
    logic [CW-1:0]  count_q;
    logic [TW-1:0]  timeoutCnt_q;
    logic           done_q;
    logic           inputErr_q;
    logic [1:0]     errCode_q;

    logic [BW-1:0]  bcd_d;
    logic [CW-1:0]  count_d;
    logic [TW-1:0]  timeoutCnt_d;
    logic           timeoutHit;
    logic           digitLegal;

`ifdef BCD_ENTRY_BIN_OUT_EN
    localparam int BINW = $clog2(10**NUM_DIGITS);
    logic [BINW-1:0] bin_q;
    logic [BINW-1:0] bin_d;
`endif

    bcd_digit_check uDigitCheck (
        .digit_i   (digit_in),
        .isLegal_o (digitLegal)
    );

    // Candidate values for a transfer and a saturating idle counter step.
    always_comb begin
        bcd_d        = (bcd_q << 4) | BW'(digit_in);
        count_d      = count_q + CW'(1);
        timeoutCnt_d = timeoutCnt_q;
        timeoutHit   = 1'b0;
        if (TIMEOUT_CYC != 0) begin
            if (timeoutCnt_q != TW'(TIMEOUT_CYC)) begin
                timeoutCnt_d = timeoutCnt_q + TW'(1);
            end
            timeoutHit = (timeoutCnt_d == TW'(TIMEOUT_CYC));
        end
`ifdef BCD_ENTRY_BIN_OUT_EN
        bin_d = BINW'(bin_q * BINW'(10)) + BINW'(digit_in);
`endif
    end

    // Main FSM; clear beats start beats transfer beats timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bcd_q        <= '0;
            count_q      <= '0;
            timeoutCnt_q <= '0;
            done_q       <= 1'b0;
            inputErr_q   <= 1'b0;
            errCode_q    <= ERR_NONE;
`ifdef BCD_ENTRY_BIN_OUT_EN
            bin_q        <= '0;
`endif
        end else if (clear || start) begin
            state_q      <= clear ? IDLE : COLLECT;
            bcd_q        <= '0;
            count_q      <= '0;
            timeoutCnt_q <= '0;
            done_q       <= 1'b0;
            inputErr_q   <= 1'b0;
            errCode_q    <= ERR_NONE;
`ifdef BCD_ENTRY_BIN_OUT_EN
            bin_q        <= '0;
`endif
        end else if (state_q == COLLECT) begin
            if (digit_valid) begin
                if (digitLegal) begin
                    bcd_q        <= bcd_d;
                    count_q      <= count_d;
                    timeoutCnt_q <= '0;
`ifdef BCD_ENTRY_BIN_OUT_EN
                    bin_q        <= bin_d;
`endif
                    if (count_d == CW'(NUM_DIGITS)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end else begin
                    state_q    <= ERROR;
                    inputErr_q <= 1'b1;
                    errCode_q  <= ERR_DIGIT;
                end
            end else begin
                timeoutCnt_q <= timeoutCnt_d;
                if (timeoutHit) begin
                    state_q    <= ERROR;
                    inputErr_q <= 1'b1;
                    errCode_q  <= ERR_TIMEOUT;
                end
            end
        end
    end

    assign digit_ready = (state_q == COLLECT);
    assign bcd_out     = bcd_q;
    assign digit_count = count_q;
    assign done        = done_q;
    assign input_err   = inputErr_q;
    assign err_code    = errCode_q;
`ifdef BCD_ENTRY_BIN_OUT_EN
    assign bin_out     = bin_q;
`endif

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Directed testbench for bcd_entry_ctrl (NUM_DIGITS=4). dut0 uses a 5-cycle
// timeout, dut1 has the timeout disabled; both share the same stimulus.
module tb_bcd_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic        digit_valid = 1'b0;

    logic        ready0, done0, err0, ready1, done1, err1;
    logic [15:0] bcd0, bcd1;
    logic [2:0]  count0, count1;
    logic [1:0]  code0, code1;
`ifdef BCD_ENTRY_BIN_OUT_EN
    logic [13:0] bin0, bin1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_entry_ctrl #(.NUM_DIGITS(4), .TIMEOUT_CYC(5)) dut0 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .digit_in(digit_in), .digit_valid(digit_valid), .digit_ready(ready0),
        .bcd_out(bcd0), .digit_count(count0), .done(done0),
        .input_err(err0), .err_code(code0)
`ifdef BCD_ENTRY_BIN_OUT_EN
        , .bin_out(bin0)
`endif
    );

    bcd_entry_ctrl #(.NUM_DIGITS(4), .TIMEOUT_CYC(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .digit_in(digit_in), .digit_valid(digit_valid), .digit_ready(ready1),
        .bcd_out(bcd1), .digit_count(count1), .done(done1),
        .input_err(err1), .err_code(code1)
`ifdef BCD_ENTRY_BIN_OUT_EN
        , .bin_out(bin1)
`endif
    );

    // Drive one cycle of inputs at the falling edge, sample 1ns after the rising edge.
    task applyStimulus(input logic s, input logic c, input logic v, input logic [3:0] d);
        @(negedge clk);
        start       = s;
        clear       = c;
        digit_valid = v;
        digit_in    = d;
        @(posedge clk);
        #1;
        start       = 1'b0;
        clear       = 1'b0;
        digit_valid = 1'b0;
    endtask

    task idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("rst_bcd",   32'(bcd0),   32'h0);
        checkOutput("rst_count", 32'(count0), 32'd0);
        checkOutput("rst_done",  32'(done0),  32'd0);
        checkOutput("rst_err",   32'(err0),   32'd0);
        checkOutput("rst_code",  32'(code0),  32'd0);
        checkOutput("rst_ready", 32'(ready0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Digit while IDLE is ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd4);
        checkOutput("idle_count", 32'(count0), 32'd0);
        checkOutput("idle_err",   32'(err0),   32'd0);

        // Normal entry 1,9,0,7
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("start_ready", 32'(ready0), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        checkOutput("n1_bcd", 32'(bcd0), 32'h0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd9);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
        checkOutput("n3_done",  32'(done0),  32'd0);
        checkOutput("n3_count", 32'(count0), 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd7);
        checkOutput("n4_bcd",   32'(bcd0),   32'h1907);
        checkOutput("n4_count", 32'(count0), 32'd4);
        checkOutput("n4_done",  32'(done0),  32'd1);
        checkOutput("n4_ready", 32'(ready0), 32'd0);
        checkOutput("n4_err",   32'(err0),   32'd0);
`ifdef BCD_ENTRY_BIN_OUT_EN
        checkOutput("n4_bin", 32'(bin0), 32'd1907);
`endif
        // Digit in DONE is ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5);
        checkOutput("done_hold", 32'(bcd0), 32'h1907);

        // Re-entry with 0,0,0,0
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("re_bcd",  32'(bcd0),  32'h0);
        checkOutput("re_done", 32'(done0), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
        checkOutput("re_fin_bcd",  32'(bcd0),  32'h0);
        checkOutput("re_fin_done", 32'(done0), 32'd1);
        checkOutput("re_fin_cnt",  32'(count0), 32'd4);
`ifdef BCD_ENTRY_BIN_OUT_EN
        checkOutput("re_bin", 32'(bin0), 32'd0);
`endif

        // Illegal digit 3, A
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'hA);
        checkOutput("ill_err",   32'(err0),   32'd1);
        checkOutput("ill_code",  32'(code0),  32'b01);
        checkOutput("ill_bcd",   32'(bcd0),   32'h0003);
        checkOutput("ill_count", 32'(count0), 32'd1);
        checkOutput("ill_done",  32'(done0),  32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd2);
        checkOutput("ill_hold", 32'(bcd0), 32'h0003);

        // Idle counter restarts on each transfer
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd2);
        idleCycles(3);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd6);
        idleCycles(4);
        checkOutput("to_rearm_ready", 32'(ready0), 32'd1);
        checkOutput("to_rearm_bcd",   32'(bcd0),   32'h0026);

        // Timeout: digit 5 then 5 idle cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5);
        idleCycles(4);
        checkOutput("to_edge_ready", 32'(ready0), 32'd1);
        checkOutput("to_edge_err",   32'(err0),   32'd0);
        idleCycles(1);
        checkOutput("to_code",  32'(code0),  32'b10);
        checkOutput("to_err",   32'(err0),   32'd1);
        checkOutput("to_bcd",   32'(bcd0),   32'h0005);
        checkOutput("to_count", 32'(count0), 32'd1);
        idleCycles(10);
        checkOutput("to_hold_code",  32'(code0),  32'b10);
        checkOutput("to_hold_ready", 32'(ready0), 32'd0);

        // Clear from ERROR
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("clr_err",  32'(err0),  32'd0);
        checkOutput("clr_code", 32'(code0), 32'd0);
        checkOutput("clr_bcd",  32'(bcd0),  32'h0);

        // start with simultaneous digit: digit not accepted
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd7);
        checkOutput("sv_count", 32'(count0), 32'd0);
        checkOutput("sv_ready", 32'(ready0), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd8);
        // clear and start together returns to IDLE
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("cs_ready", 32'(ready0), 32'd0);
        checkOutput("cs_count", 32'(count0), 32'd0);

        // Timeout disabled: 1000 idle cycles stays collecting
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5);
        idleCycles(1000);
        checkOutput("nto_ready", 32'(ready1), 32'd1);
        checkOutput("nto_err",   32'(err1),   32'd0);
        checkOutput("nto_bcd",   32'(bcd1),   32'h0005);

        // Async reset mid-entry
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd2);
        checkOutput("pre_rst_bcd", 32'(bcd0), 32'h0042);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_bcd",   32'(bcd0),   32'h0);
        checkOutput("arst_count", 32'(count0), 32'd0);
        checkOutput("arst_ready", 32'(ready0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
